// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences every RAM access of the CPU. It latches the memory
//               address register (MAR), strobes RAM read or write, waits out
//               the RAM read latency, captures read data into the MDR and
//               returns a one-cycle completion pulse. Two requesters
//               (instruction fetch, read-only, and data load/store) share the
//               single RAM port under round-robin arbitration.
// Ports       : clock      - system clock, all state changes on posedge
//               clear      - synchronous active-high reset
//               if_req/if_addr/if_ack            - fetch requester
//               d_req/d_we/d_addr/d_wdata/d_ack  - data requester
//               rd_data    - registered read data (MDR)
//               ram_addr   - registered RAM address (MAR)
//               ram_wdata  - registered store data
//               ram_read/ram_write - RAM strobes
//               ram_rdata  - RAM read data, valid RAM_LAT cycles after ram_read
//               busy       - high whenever the controller is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(RAM_LAT + 1);
    localparam logic [CNT_W-1:0] c_LAT = CNT_W'(RAM_LAT);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic               r_last_data, w_last_data_nxt;  // 1: data won the last grant
    logic               r_grant_data, w_grant_data_nxt;
    logic               r_we,        w_we_nxt;
    logic [ADDR_W-1:0]  r_addr,      w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata,     w_wdata_nxt;
    logic [DATA_W-1:0]  r_rd_data,   w_rd_data_nxt;
    logic               r_read,      w_read_nxt;
    logic               r_write,     w_write_nxt;
    logic               r_if_ack,    w_if_ack_nxt;
    logic               r_d_ack,     w_d_ack_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               w_pick_data;
    logic               w_store;

    // Data wins when it is the only requester, or on a tie when fetch was
    // served last.
    assign w_pick_data = d_req && (!if_req || !r_last_data);
    assign w_store     = w_pick_data && d_we;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_data_nxt  = r_last_data;
        w_grant_data_nxt = r_grant_data;
        w_we_nxt         = r_we;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_rd_data_nxt    = r_rd_data;
        w_read_nxt       = 1'b0;
        w_write_nxt      = 1'b0;
        w_if_ack_nxt     = 1'b0;
        w_d_ack_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    w_grant_data_nxt = w_pick_data;
                    w_last_data_nxt  = w_pick_data;
                    w_we_nxt         = w_store;
                    w_addr_nxt       = w_pick_data ? d_addr : if_addr;
                    if (w_store) begin
                        w_wdata_nxt = d_wdata;
                    end
                    // Strobes are registered, so they are raised here to be
                    // visible during the ACCESS cycle.
                    w_read_nxt  = !w_store;
                    w_write_nxt = w_store;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    w_d_ack_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = c_LAT;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - c_ONE;
                // Counter never legally reaches 0 here; <= guards against a
                // stuck state if it ever did.
                if (r_cnt <= c_ONE) begin
                    w_rd_data_nxt = ram_rdata;
                    w_if_ack_nxt  = !r_grant_data;
                    w_d_ack_nxt   = r_grant_data;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_data  <= 1'b1;
            r_grant_data <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_data    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_data  <= w_last_data_nxt;
            r_grant_data <= w_grant_data_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_read       <= w_read_nxt;
            r_write      <= w_write_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_read  = r_read;
    assign ram_write = r_write;
    assign rd_data   = r_rd_data;
    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Instance A uses
//               RAM_LAT=1 (reset, round-robin tie, store, fetch); instance B
//               uses RAM_LAT=3 (slow load, abort by clear). A small RAM model
//               serves both; a queue holds expected completions of instance A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam logic [DW-1:0] c_JUNK = 32'h0BAD_0BAD;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A (RAM_LAT=1)
    logic          a_clear, a_if_req, a_d_req, a_d_we;
    logic [AW-1:0] a_if_addr, a_d_addr;
    logic [DW-1:0] a_d_wdata, a_rd_data, a_ram_wdata, a_ram_rdata;
    logic [AW-1:0] a_ram_addr;
    logic          a_if_ack, a_d_ack, a_ram_read, a_ram_write, a_busy;

    // Instance B (RAM_LAT=3)
    logic          b_clear, b_if_req, b_d_req, b_d_we;
    logic [AW-1:0] b_if_addr, b_d_addr;
    logic [DW-1:0] b_d_wdata, b_rd_data, b_ram_wdata, b_ram_rdata;
    logic [AW-1:0] b_ram_addr;
    logic          b_if_ack, b_d_ack, b_ram_read, b_ram_write, b_busy;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) u_a (
        .clock(clock), .clear(a_clear),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .rd_data(a_rd_data), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_read(a_ram_read), .ram_write(a_ram_write),
        .ram_rdata(a_ram_rdata), .busy(a_busy)
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) u_b (
        .clock(clock), .clear(b_clear),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .rd_data(b_rd_data), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_read(b_ram_read), .ram_write(b_ram_write),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // RAM model: only instance A writes; read data appears RAM_LAT cycles
    // after the read strobe cycle, junk otherwise.
    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] pipe_b [0:2];
    always @(posedge clock) begin
        if (a_ram_write) mem[a_ram_addr] <= a_ram_wdata;
        a_ram_rdata <= a_ram_read ? mem[a_ram_addr] : c_JUNK;
        pipe_b[0]   <= b_ram_read ? mem[b_ram_addr] : c_JUNK;
        pipe_b[1]   <= pipe_b[0];
        pipe_b[2]   <= pipe_b[1];
    end
    assign b_ram_rdata = pipe_b[2];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard of expected completions for instance A
    typedef struct {
        bit            fetch;
        logic [DW-1:0] rd;
    } exp_t;
    exp_t sb[$];

    always @(negedge clock) begin
        if (a_if_ack === 1'b1 || a_d_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_if_ack", 64'(a_if_ack), 64'(e.fetch));
                check("sb_d_ack", 64'(a_d_ack), 64'(!e.fetch));
                check("sb_rd_data", 64'(a_rd_data), 64'(e.rd));
            end
        end
    end

    initial begin
        int acks;
        int ack_cyc[4];
        int t0;
        bit done;

        for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
        mem[9'h010] = 32'h1234_5678;
        mem[9'h030] = 32'h55AA_33CC;
        mem[9'h1FF] = 32'hCAFE_F00D;

        // Reset with both requests high on A
        a_clear = 1; a_if_req = 1; a_d_req = 1; a_d_we = 1;
        a_if_addr = 9'h030; a_d_addr = 9'h020; a_d_wdata = 32'h0A0B_0C0D;
        b_clear = 1; b_if_req = 0; b_d_req = 0; b_d_we = 0;
        b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;

        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_strobes", {a_ram_read, a_ram_write}, 0);
            check("rst_acks", {a_if_ack, a_d_ack}, 0);
            check("rst_busy", 64'(a_busy), 0);
            check("rst_rd_data", 64'(a_rd_data), 0);
            check("rst_ram_addr", 64'(a_ram_addr), 0);
            check("rst_ram_wdata", 64'(a_ram_wdata), 0);
            check("rst_b_outs", {b_busy, b_rd_data, b_ram_read, b_if_ack, b_d_ack}, 0);
        end

        // Tie: fetch (last_grant=DATA after reset), data, fetch, data
        sb.push_back('{1'b1, 32'h55AA_33CC});
        sb.push_back('{1'b0, 32'h55AA_33CC});
        sb.push_back('{1'b1, 32'h55AA_33CC});
        sb.push_back('{1'b0, 32'h55AA_33CC});
        a_clear = 0; b_clear = 0;
        acks = 0;
        for (int k = 0; k < 40 && acks < 4; k++) begin
            tick();
            if (a_if_ack || a_d_ack) begin
                ack_cyc[acks] = cyc;
                acks++;
            end
        end
        a_if_req = 0; a_d_req = 0;
        check("tie_ack_count", acks, 4);
        if (acks == 4) begin
            check("tie_gap_f_d", ack_cyc[1] - ack_cyc[0], 3);
            check("tie_gap_d_f", ack_cyc[2] - ack_cyc[1], 4);
            check("tie_gap_f_d2", ack_cyc[3] - ack_cyc[2], 3);
        end
        tick();
        tick();
        check("tie_idle_busy", 64'(a_busy), 0);
        check("tie_store_mem", 64'(mem[9'h020]), 64'h0A0B_0C0D);

        // Store on A (data won last, but fetch is not requesting)
        a_d_req = 1; a_d_we = 1; a_d_addr = 9'h1A5; a_d_wdata = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 32'h55AA_33CC});
        tick();  // cycle 1
        check("st_ram_write_c1", 64'(a_ram_write), 1);
        check("st_ram_read_c1", 64'(a_ram_read), 0);
        check("st_ram_addr", 64'(a_ram_addr), 64'h1A5);
        check("st_ram_wdata", 64'(a_ram_wdata), 64'hDEAD_BEEF);
        check("st_no_ack_c1", {a_if_ack, a_d_ack}, 0);
        tick();  // cycle 2
        check("st_d_ack_c2", 64'(a_d_ack), 1);
        check("st_if_ack_c2", 64'(a_if_ack), 0);
        check("st_ram_write_c2", 64'(a_ram_write), 0);
        check("st_rd_data_kept", 64'(a_rd_data), 64'h55AA_33CC);
        a_d_req = 0;
        tick();  // cycle 3
        check("st_ack_gone", 64'(a_d_ack), 0);
        check("st_busy_c3", 64'(a_busy), 0);
        check("st_mem", 64'(mem[9'h1A5]), 64'hDEAD_BEEF);
        check("st_ram_addr_held", 64'(a_ram_addr), 64'h1A5);

        // Fetch on A, RAM_LAT=1: ack in cycle 3
        a_if_req = 1; a_if_addr = 9'h010;
        sb.push_back('{1'b1, 32'h1234_5678});
        tick();  // cycle 1
        check("f_ram_read_c1", 64'(a_ram_read), 1);
        check("f_ram_addr", 64'(a_ram_addr), 64'h010);
        check("f_busy_c1", 64'(a_busy), 1);
        tick();  // cycle 2
        check("f_ram_read_c2", 64'(a_ram_read), 0);
        check("f_no_ack_c2", {a_if_ack, a_d_ack}, 0);
        tick();  // cycle 3
        check("f_if_ack_c3", 64'(a_if_ack), 1);
        check("f_rd_data", 64'(a_rd_data), 64'h1234_5678);
        a_if_req = 0;
        tick();
        check("f_ack_gone", 64'(a_if_ack), 0);
        check("f_rd_data_held", 64'(a_rd_data), 64'h1234_5678);

        // RAM_LAT=3 load on B: d_ack in cycle 5
        b_d_req = 1; b_d_we = 0; b_d_addr = 9'h1FF;
        tick();  // cycle 1
        check("l3_ram_read_c1", 64'(b_ram_read), 1);
        check("l3_ram_addr", 64'(b_ram_addr), 64'h1FF);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check("l3_ram_read_wait", 64'(b_ram_read), 0);
            check("l3_no_ack_wait", {b_if_ack, b_d_ack}, 0);
        end
        tick();  // cycle 5
        check("l3_d_ack_c5", 64'(b_d_ack), 1);
        check("l3_if_ack_c5", 64'(b_if_ack), 0);
        check("l3_rd_data", 64'(b_rd_data), 64'hCAFE_F00D);
        b_d_req = 0;
        tick();
        check("l3_ack_gone", 64'(b_d_ack), 0);

        // Abort on B: clear during WAIT, then a fresh fetch completes
        b_if_req = 1; b_if_addr = 9'h010;
        tick();  // cycle 1 ACCESS
        tick();  // cycle 2 WAIT
        check("ab_busy_wait", 64'(b_busy), 1);
        b_clear = 1;
        tick();
        b_clear = 0;
        check("ab_busy", 64'(b_busy), 0);
        check("ab_strobes", {b_ram_read, b_ram_write}, 0);
        check("ab_rd_data", 64'(b_rd_data), 0);
        check("ab_acks", {b_if_ack, b_d_ack}, 0);
        // if_req still high: sampled in this IDLE cycle, ack 2+3 cycles later
        t0 = cyc;
        done = 0;
        for (int k = 0; k < 12 && !done; k++) begin
            tick();
            check("ab_no_d_ack", 64'(b_d_ack), 0);
            if (b_if_ack) done = 1;
        end
        b_if_req = 0;
        check("ab_refetch_done", 64'(done), 1);
        check("ab_refetch_latency", cyc - t0, 5);
        check("ab_refetch_data", 64'(b_rd_data), 64'h1234_5678);

        tick();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
